// File: rtl/fp_const_pkg.sv
// Shared floating-point angle constants, field widths and sequencer state encoding
// for the CORDIC range-reduction front end and rotation stages.
package fp_const_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned FP_W   = SIGN_W + EXP_W + MANT_W;

    localparam logic [FP_W-1:0] PI_2  = 32'h3FC9_0FDB;
    localparam logic [FP_W-1:0] PI    = 32'h4049_0FDB;
    localparam logic [FP_W-1:0] PI3_2 = 32'h4096_CBE4;
    localparam logic [FP_W-1:0] PI2   = 32'h40C9_0FDB;

    typedef enum logic [2:0] {
        IDLE,
        RANGE,
        MID,
        FINE,
        DONE
    } fp_seq_state_e;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [FP_W-1:0] fp_abs(input logic [FP_W-1:0] x);
        return {1'b0, x[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/compare_floating_point.sv
// Single-precision greater-than comparator (gt = a > b strictly).
// NaN patterns order by their bit magnitude, so a positive NaN exceeds every finite value.
module compare_floating_point
    import fp_const_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            gt
);

    logic                   a_sign;
    logic                   b_sign;
    logic [FP_W-2:0]        a_mag;
    logic [FP_W-2:0]        b_mag;
    logic                   both_zero;

    assign a_sign    = fp_sign(a);
    assign b_sign    = fp_sign(b);
    assign a_mag     = a[FP_W-2:0];
    assign b_mag     = b[FP_W-2:0];
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    always_comb begin
        gt = 1'b0;
        if (a_sign != b_sign) begin
            // +0 and -0 are equal, so neither exceeds the other
            gt = !a_sign && !both_zero;
        end else if (!a_sign) begin
            gt = a_mag > b_mag;
        end else begin
            gt = a_mag < b_mag;
        end
    end

endmodule

// File: rtl/fp_quadrant_sequencer.sv
// Quadrant classifier for the CORDIC sin path: binary-searches the angle against
// pi/2, pi, 3pi/2, 2pi on one shared comparator. Optional counters: FP_QUAD_STATS_EN.
module fp_quadrant_sequencer
    import fp_const_pkg::*;
#(
    parameter bit NEG_IS_ERR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_angle,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_angle,
    output logic [1:0]      out_quadrant,
    output logic            out_sin_neg,
    output logic            out_mirror,
    output logic            out_err
`ifdef FP_QUAD_STATS_EN
    ,
    output logic [15:0]     stat_done,
    output logic [15:0]     stat_err
`endif
);

    fp_seq_state_e   state_q, state_d;
    logic [FP_W-1:0] angle_q, angle_d;
    logic [1:0]      quad_q, quad_d;
    logic            err_q, err_d;
    logic [FP_W-1:0] cmp_a;
    logic [FP_W-1:0] cmp_b;
    logic            gt;

    // The comparator only ever sees a non-negative operand; a set sign bit
    // is handled by the range check instead.
    assign cmp_a = fp_abs(angle_q);

    compare_floating_point u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (gt)
    );

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        quad_d  = quad_q;
        err_d   = err_q;
        cmp_b   = PI2;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    angle_d = NEG_IS_ERR ? in_angle : fp_abs(in_angle);
                    quad_d  = '0;
                    err_d   = 1'b0;
                    state_d = RANGE;
                end
            end
            RANGE: begin
                cmp_b = PI2;
                if ((NEG_IS_ERR && fp_sign(angle_q)) || gt) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = MID;
                end
            end
            MID: begin
                cmp_b     = PI;
                quad_d[1] = gt;
                state_d   = FINE;
            end
            FINE: begin
                cmp_b     = quad_q[1] ? PI3_2 : PI_2;
                quad_d[0] = gt;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            angle_q <= '0;
            quad_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            quad_q  <= quad_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_angle    = angle_q;
    assign out_quadrant = quad_q;
    assign out_sin_neg  = quad_q[1];
    assign out_mirror   = quad_q[0];
    assign out_err      = err_q;

`ifdef FP_QUAD_STATS_EN
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_err_q, stat_err_d;
    logic        retire;

    assign retire = (state_q == DONE) && out_ready;

    always_comb begin
        stat_done_d = stat_done_q;
        stat_err_d  = stat_err_q;
        if (retire) begin
            if (stat_done_q != '1) begin
                stat_done_d = stat_done_q + 16'd1;
            end
            if (err_q && (stat_err_q != '1)) begin
                stat_err_d = stat_err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done_q <= '0;
            stat_err_q  <= '0;
        end else begin
            stat_done_q <= stat_done_d;
            stat_err_q  <= stat_err_d;
        end
    end

    assign stat_done = stat_done_q;
    assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_fp_quadrant_sequencer.sv
// Self-checking bench for fp_quadrant_sequencer: directed angles, boundaries, errors,
// backpressure, mid-flight reset and randomized angles against a real-valued model.
`timescale 1ns/1ps
module tb_fp_quadrant_sequencer;

    localparam logic [31:0] C_PI_2  = 32'h3FC9_0FDB;
    localparam logic [31:0] C_PI    = 32'h4049_0FDB;
    localparam logic [31:0] C_PI3_2 = 32'h4096_CBE4;
    localparam logic [31:0] C_PI2   = 32'h40C9_0FDB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_angle = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_angle;
    logic [1:0]  out_quadrant;
    logic        out_sin_neg;
    logic        out_mirror;
    logic        out_err;
`ifdef FP_QUAD_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_err;
`endif

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    fp_quadrant_sequencer #(.NEG_IS_ERR(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_angle     (in_angle),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_angle    (out_angle),
        .out_quadrant (out_quadrant),
        .out_sin_neg  (out_sin_neg),
        .out_mirror   (out_mirror),
        .out_err      (out_err)
`ifdef FP_QUAD_STATS_EN
        ,
        .stat_done    (stat_done),
        .stat_err     (stat_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Decode a finite single-precision pattern into a real value.
    function automatic real f2r(input logic [31:0] b);
        int unsigned e = b[30:23];
        real m = real'(b[22:0]);
        real v;
        if (e == 0) v = m * (2.0 ** (-149.0));
        else        v = (1.0 + m / 8388608.0) * (2.0 ** (real'(e) - 127.0));
        return b[31] ? -v : v;
    endfunction

    // Quadrant intervals: boundary values fall into the lower quadrant.
    task automatic model(input logic [31:0] a, output logic [1:0] q, output logic e);
        real x;
        q = 2'd0;
        e = 1'b0;
        if (a[31]) begin
            e = 1'b1;
        end else if (a[30:23] == 8'hFF) begin
            e = 1'b1;
        end else begin
            x = f2r(a);
            if (x > f2r(C_PI2))        e = 1'b1;
            else if (x > f2r(C_PI3_2)) q = 2'd3;
            else if (x > f2r(C_PI))    q = 2'd2;
            else if (x > f2r(C_PI_2))  q = 2'd1;
        end
    endtask

    task automatic run(input logic [31:0] a, input int unsigned stall,
                       input bit queue, input logic [31:0] nxt);
        logic [1:0] eq;
        logic       ee;
        int         n;
        model(a, eq, ee);
        in_angle = a;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, ee ? 32'd2 : 32'd4);
        check("quadrant", {30'd0, out_quadrant}, {30'd0, eq});
        check("sin_neg", {31'd0, out_sin_neg}, {31'd0, eq[1]});
        check("mirror", {31'd0, out_mirror}, {31'd0, eq[0]});
        check("err", {31'd0, out_err}, {31'd0, ee});
        check("angle", out_angle, a);
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        if (queue) begin
            in_angle = nxt;
            in_valid = 1'b1;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_quadrant", {30'd0, out_quadrant}, {30'd0, eq});
        check("hold_err", {31'd0, out_err}, {31'd0, ee});
        check("hold_angle", out_angle, a);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        exp_done++;
        if (ee) exp_errs++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dir[14];
        logic [31:0] a;
        logic [31:0] bnd;
        dir = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h40A0_0000,
                C_PI, C_PI2, 32'h0000_0000, 32'h40E0_0000, 32'hBF80_0000,
                32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000, C_PI_2, C_PI3_2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quadrant", {30'd0, out_quadrant}, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_angle", out_angle, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dir[i]) run(dir[i], 1, 1'b0, '0);

        // 5.0 held under backpressure with 1.0 queued behind it
        run(32'h40A0_0000, 6, 1'b1, 32'h3F80_0000);
        run(32'h3F80_0000, 0, 1'b0, '0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    bnd = (i % 4 == 0) ? C_PI_2 : (i % 4 == 1) ? C_PI :
                          (i % 4 == 2) ? C_PI3_2 : C_PI2;
                    a = $urandom_range(0, 1) ? bnd + 32'd1 : bnd - 32'd1;
                end
                1: a = {1'b1, 8'($urandom_range(8'h70, 8'h81)), 23'($urandom)};
                2: a = {1'b0, 8'hFF, 23'($urandom)};
                default: a = {1'b0, 8'($urandom_range(8'h60, 8'h82)), 23'($urandom)};
            endcase
            run(a, $urandom_range(0, 3), 1'b0, '0);
        end

`ifdef FP_QUAD_STATS_EN
        check("stat_done_run", {16'd0, stat_done}, exp_done);
        check("stat_err_run", {16'd0, stat_err}, exp_errs);
`endif

        // Reset while the sequencer sits in MID
        in_angle = 32'h40A0_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quadrant", {30'd0, out_quadrant}, 32'd0);
        check("midrst_err", {31'd0, out_err}, 32'd0);
        check("midrst_angle", out_angle, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef FP_QUAD_STATS_EN
        check("midrst_stat_done", {16'd0, stat_done}, 32'd0);
        check("midrst_stat_err", {16'd0, stat_err}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 0;
        exp_errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run(32'h3F80_0000, 0, 1'b0, '0);
        run(32'h40E0_0000, 0, 1'b0, '0);
`ifdef FP_QUAD_STATS_EN
        check("stat_done_final", {16'd0, stat_done}, 32'd2);
        check("stat_err_final", {16'd0, stat_err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
